// File: rtl/nor_chain_pkg.sv
// Shared types and helpers for the NOR2 delay-chain pulse tester.
// Stage k of an inverting chain idles at 1 when k is even, 0 when odd.
package nor_chain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  localparam int SETTLE_PAD = 3;

  function automatic logic idle_level(input int k);
    return ((k % 2) == 0);
  endfunction

endpackage

// File: rtl/nor_chain_pulse_tester_if.sv
// Harness-side control/status bundle of the NOR chain pulse tester.
interface nor_chain_pulse_tester_if #(
  parameter int STAGES = 6,
  parameter int PW_W   = 8,
  parameter int CNT_W  = 8,
  parameter int TAP_W  = $clog2(STAGES)
);

  logic              start;
  logic [PW_W-1:0]   pulse_width;
  logic [PW_W-1:0]   settle_cycles;
  logic [CNT_W-1:0]  num_pulses;
  logic [TAP_W-1:0]  tap_sel;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  pulse_count;
  logic [STAGES-1:0] tap_sample;

  modport master (
    output start, pulse_width, settle_cycles, num_pulses, tap_sel,
    input  busy, done, pulse_count, tap_sample
  );

  modport slave (
    input  start, pulse_width, settle_cycles, num_pulses, tap_sel,
    output busy, done, pulse_count, tap_sample
  );

endinterface

// File: rtl/nor2_x1.sv
// Behavioural model of the NOR2_X1 standard cell used by the delay chain.
module NOR2_X1 (
  input  logic A1,
  input  logic A2,
  output logic ZN
);

  assign ZN = ~(A1 | A2);

endmodule

// File: rtl/nor_chain_pulse_tester_chain.sv
// Purely combinational chain of NOR2_X1 cells, each wired as an inverter
// through its grounded second input; every stage output is exposed as a tap.
module nor_chain #(
  parameter int STAGES = 6
) (
  input  logic              chain_in,
  input  logic              mygnd,
  output logic [STAGES-1:0] taps
);

  // Per-stage nets live inside the generate blocks so no vector feeds itself.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic a1;
    logic zn;

    if (k == 0) begin : g_first
      assign a1 = chain_in;
    end else begin : g_next
      assign a1 = g_stage[k-1].zn;
    end

    NOR2_X1 u_nor (
      .A1(a1),
      .A2(mygnd),
      .ZN(zn)
    );

    assign taps[k] = zn;
  end

endmodule

// File: rtl/nor_chain_pulse_tester.sv
// Launches a programmable pulse train into a NOR2 chain, counts arrivals at a
// selected tap through 2-flop synchronisers and snapshots all taps at run end.
module nor_chain_pulse_tester
  import nor_chain_pkg::*;
#(
  parameter int STAGES = 6,
  parameter int PW_W   = 8,
  parameter int CNT_W  = 8,
  parameter int TAP_W  = $clog2(STAGES)
) (
  input  logic                     myclk,
  input  logic                     myrst_n,
  input  logic                     mygnd,
  nor_chain_pulse_tester_if.slave  bus,
  output logic                     myout
);

  localparam int CW = PW_W + 2;

  state_t            state;
  logic              launch;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     pw_m1;
  logic [PW_W-1:0]   settle_r;
  logic [CNT_W-1:0]  pulses_left;
  logic [TAP_W-1:0]  tap_r;
  logic [STAGES-1:0] taps;
  logic [STAGES-1:0] sync1;
  logic [STAGES-1:0] sync2;
  logic [STAGES-1:0] sync3;
  logic [STAGES-1:0] idle_pat;
  logic              tap_ok;
  logic              arrival;

  function automatic logic [CW-1:0] width_m1(input logic [PW_W-1:0] w);
    return (w == '0) ? '0 : (CW'(w) - CW'(1));
  endfunction

  function automatic logic [CW-1:0] settle_load(input logic [PW_W-1:0] s);
    return CW'(s) + CW'(SETTLE_PAD - 1);
  endfunction

  nor_chain #(.STAGES(STAGES)) u_chain (
    .chain_in(launch),
    .mygnd   (mygnd),
    .taps    (taps)
  );

  assign myout = taps[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_idle
    assign idle_pat[k] = idle_level(k);
  end

  always_ff @(posedge myclk or negedge myrst_n) begin
    if (!myrst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= taps;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // An arrival is the synchronised tap leaving its idle level for the active one.
  assign tap_ok  = (int'(tap_r) < STAGES);
  assign arrival = tap_ok && (sync3[tap_r] == idle_pat[tap_r]) &&
                   (sync2[tap_r] != idle_pat[tap_r]);

  always_ff @(posedge myclk or negedge myrst_n) begin
    if (!myrst_n) begin
      state       <= IDLE;
      launch      <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.pulse_count <= '0;
      bus.tap_sample  <= '0;
      cnt         <= '0;
      pw_m1       <= '0;
      settle_r    <= '0;
      pulses_left <= '0;
      tap_r       <= '0;
    end else begin
      bus.done <= 1'b0;
      if (state != IDLE && arrival && bus.pulse_count != '1)
        bus.pulse_count <= bus.pulse_count + CNT_W'(1);

      case (state)
        IDLE: begin
          if (bus.start) begin
            pw_m1           <= width_m1(bus.pulse_width);
            settle_r        <= bus.settle_cycles;
            tap_r           <= bus.tap_sel;
            bus.pulse_count <= '0;
            bus.busy        <= 1'b1;
            if (bus.num_pulses != '0) begin
              pulses_left <= bus.num_pulses;
              cnt         <= width_m1(bus.pulse_width);
              launch      <= 1'b1;
              state       <= LAUNCH;
            end else begin
              state <= CAPTURE;
            end
          end
        end

        LAUNCH: begin
          if (cnt == '0) begin
            launch <= 1'b0;
            cnt    <= settle_load(settle_r);
            state  <= SETTLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        // The settle pad lets the last arrival clear the synchronisers first.
        SETTLE: begin
          if (cnt == '0) begin
            if (pulses_left > CNT_W'(1)) begin
              pulses_left <= pulses_left - CNT_W'(1);
              cnt         <= pw_m1;
              launch      <= 1'b1;
              state       <= LAUNCH;
            end else begin
              state <= CAPTURE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        CAPTURE: begin
          bus.tap_sample <= sync2;
          bus.done       <= 1'b1;
          bus.busy       <= 1'b0;
          state          <= DONE;
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nor_chain_pulse_tester.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and randomized runs compared against a run-level timing/count model.
module tb_nor_chain_pulse_tester;

  localparam int STAGES = 6;

  logic myclk   = 1'b0;
  logic myrst_n = 1'b0;
  logic mygnd   = 1'b0;
  logic myout;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 myclk = ~myclk;

  nor_chain_pulse_tester_if #(.STAGES(STAGES)) bus ();

  nor_chain_pulse_tester #(.STAGES(STAGES)) u_dut (
    .myclk  (myclk),
    .myrst_n(myrst_n),
    .mygnd  (mygnd),
    .bus    (bus.slave),
    .myout  (myout)
  );

  typedef struct {
    int         pw;
    int         st;
    int         np;
    int         tap;
    int         restart;
    int         exp_done;
    int         exp_count;
    logic [5:0] exp_sample;
    int         exp_hi;
  } vec_t;

  vec_t vecs[7];

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_done(input int pw, input int st, input int np);
    int wp;
    wp = (pw == 0) ? 1 : pw;
    return np * (wp + st + 3) + 2;
  endfunction

  function automatic logic [5:0] model_idle();
    logic [5:0] p;
    for (int k = 0; k < STAGES; k++) p[k] = ((k % 2) == 0);
    return p;
  endfunction

  // Runs one start request from a negedge in IDLE; restart>0 re-asserts start
  // in that cycle of the run, which must be ignored.
  task automatic apply_stimulus(input int pw, input int st, input int np, input int tap,
                                input int restart, input int limit,
                                output int done_cyc, output int cnt, output int sample,
                                output int hi, output int busy_n, output int dp);
    done_cyc = -1; cnt = 0; sample = 0; hi = 0; busy_n = 0; dp = 0;
    @(negedge myclk);
    bus.start         = 1'b1;
    bus.pulse_width   = 8'(pw);
    bus.settle_cycles = 8'(st);
    bus.num_pulses    = 8'(np);
    bus.tap_sel       = 3'(tap);
    @(negedge myclk);
    bus.start         = 1'b0;
    bus.pulse_width   = 8'($urandom_range(0, 9));
    bus.settle_cycles = 8'($urandom_range(0, 9));
    bus.num_pulses    = 8'($urandom_range(1, 9));
    bus.tap_sel       = 3'($urandom_range(0, 5));
    for (int c = 1; c <= limit; c++) begin
      bus.start = (c == restart);
      if (bus.busy) busy_n++;
      if (myout) hi++;
      if (bus.done) begin
        dp++;
        if (done_cyc < 0) begin
          done_cyc = c;
          cnt      = int'(bus.pulse_count);
          sample   = int'(bus.tap_sample);
        end
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      @(negedge myclk);
    end
    bus.start = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input vec_t v);
    int done_cyc, cnt, sample, hi, busy_n, dp;
    apply_stimulus(v.pw, v.st, v.np, v.tap, v.restart, v.exp_done + 12,
                   done_cyc, cnt, sample, hi, busy_n, dp);
    check_output({tag, ".done_cycle"}, done_cyc, v.exp_done);
    check_output({tag, ".pulse_count"}, cnt, v.exp_count);
    check_output({tag, ".tap_sample"}, sample, int'(v.exp_sample));
    check_output({tag, ".myout_high"}, hi, v.exp_hi);
    check_output({tag, ".busy_cycles"}, busy_n, v.exp_done - 1);
    check_output({tag, ".done_pulses"}, dp, 1);
  endtask

  initial begin
    int dp;
    vec_t v;

    bus.start = 1'b0; bus.pulse_width = '0; bus.settle_cycles = '0;
    bus.num_pulses = '0; bus.tap_sel = '0;

    //                pw st np tap rs done cnt sample     hi
    vecs[0] = '{2, 2, 1, 5, 0,  9, 1, 6'b010101,  2};
    vecs[1] = '{3, 1, 4, 5, 0, 30, 4, 6'b010101, 12};
    vecs[2] = '{1, 2, 3, 0, 0, 20, 3, 6'b010101,  3};
    vecs[3] = '{1, 2, 3, 5, 0, 20, 3, 6'b010101,  3};
    vecs[4] = '{0, 0, 0, 5, 0,  2, 0, 6'b010101,  0};
    vecs[5] = '{0, 1, 1, 5, 0,  7, 1, 6'b010101,  1};
    vecs[6] = '{3, 1, 4, 5, 5, 30, 4, 6'b010101, 12};

    #12;
    check_output("reset.busy", int'(bus.busy), 0);
    check_output("reset.done", int'(bus.done), 0);
    check_output("reset.pulse_count", int'(bus.pulse_count), 0);
    check_output("reset.tap_sample", int'(bus.tap_sample), 0);
    check_output("reset.myout", int'(myout), 0);
    @(negedge myclk);
    myrst_n = 1'b1;
    repeat (4) @(negedge myclk);

    for (int i = 0; i < 7; i++) run_and_check($sformatf("vec%0d", i), vecs[i]);

    // Reset asserted mid-LAUNCH must abort at once with no done pulse.
    @(negedge myclk);
    bus.start = 1'b1; bus.pulse_width = 8'd5; bus.settle_cycles = 8'd0;
    bus.num_pulses = 8'd2; bus.tap_sel = 3'd5;
    @(negedge myclk);
    bus.start = 1'b0;
    @(negedge myclk);
    check_output("midrst.busy_before", int'(bus.busy), 1);
    check_output("midrst.myout_before", int'(myout), 1);
    #2 myrst_n = 1'b0;
    #1;
    check_output("midrst.busy", int'(bus.busy), 0);
    check_output("midrst.myout", int'(myout), 0);
    check_output("midrst.pulse_count", int'(bus.pulse_count), 0);
    dp = 0;
    repeat (3) begin
      @(negedge myclk);
      if (bus.done) dp++;
    end
    myrst_n = 1'b1;
    repeat (12) begin
      @(negedge myclk);
      if (bus.done) dp++;
    end
    check_output("midrst.done_pulses", dp, 0);
    run_and_check("after_rst", vecs[0]);

    for (int i = 0; i < 10; i++) begin
      v.pw  = $urandom_range(0, 4);
      v.st  = $urandom_range(0, 3);
      v.np  = $urandom_range(0, 5);
      v.tap = $urandom_range(0, STAGES - 1);
      v.exp_done   = model_done(v.pw, v.st, v.np);
      v.restart    = (i % 3 == 0) ? $urandom_range(1, v.exp_done - 1) : 0;
      v.exp_count  = v.np;
      v.exp_sample = model_idle();
      v.exp_hi     = v.np * ((v.pw == 0) ? 1 : v.pw);
      run_and_check($sformatf("rand%0d", i), v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
